// File: rtl/sentinel_sequence_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sentinel_pkg
// Purpose  : Shared types and constants for the Sentinel sequence lock:
//            FSM state encoding, 7-segment glyphs (active low) and a small
//            thermometer helper used for the entry-progress status array.
// Revision : 1.0 - initial release
// ============================================================================
package sentinel_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } sentinel_state_e;

    // {dp,g,f,e,d,c,b,a}, active low
    localparam logic [7:0] SEG_LOCKED   = 8'hC7;  // 'L'
    localparam logic [7:0] SEG_UNLOCKED = 8'hC1;  // 'U'
    localparam logic [7:0] SEG_LOCKOUT  = 8'hBF;  // '-'
    localparam logic [7:0] SEG_OFF      = 8'hFF;

    // n low bits set, saturating at 8 (n=2 -> 8'h03)
    function automatic logic [7:0] therm8(input int unsigned n);
        logic [7:0] t;
        t = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            t[i] = (i < n);
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sentinel_sequence_lock_if.sv
`default_nettype none
// ============================================================================
// Module   : sentinel_sequence_lock_if
// Purpose  : Key-entry inputs and display/status outputs of the sequence lock.
//            master : drives ena/key_in/key_strobe, observes outputs
//            slave  : the lock itself
// Ports    : ena, key_in[KEY_W], key_strobe -> lock
//            seg_out[8], status[8], unlocked, lockout, fail_count -> wrapper
// Revision : 1.0 - initial release
// ============================================================================
interface sentinel_sequence_lock_if #(
    parameter int KEY_W     = 8,
    parameter int MAX_FAILS = 3
);
    localparam int FC_W = $clog2(MAX_FAILS + 1);

    logic             ena;
    logic [KEY_W-1:0] key_in;
    logic             key_strobe;
    logic [7:0]       seg_out;
    logic [7:0]       status;
    logic             unlocked;
    logic             lockout;
    logic [FC_W-1:0]  fail_count;

    modport master (
        output ena, key_in, key_strobe,
        input  seg_out, status, unlocked, lockout, fail_count
    );

    modport slave (
        input  ena, key_in, key_strobe,
        output seg_out, status, unlocked, lockout, fail_count
    );
endinterface
`default_nettype wire

// File: rtl/sentinel_sequence_lock_countdown.sv
`default_nettype none
// ============================================================================
// Module   : sentinel_countdown
// Purpose  : Loadable down-counter shared by the lockout and auto-relock
//            paths. Counts down while en is high, stops at zero, and flags
//            done in the enabled cycle where the count is 1.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            en, load        - count enable, synchronous load (load wins)
//            load_val[W]     - value loaded
//            done            - en && count==1
//            tap             - count bit TAP (0 if the counter is narrower)
// Revision : 1.0 - initial release
// ============================================================================
module sentinel_countdown #(
    parameter int W   = 4,
    parameter int TAP = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         tap
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = en && (count_q == W'(1));

    generate
        if (W > TAP) begin : g_tap
            assign tap = count_q[TAP];
        end else begin : g_no_tap
            assign tap = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sentinel_sequence_lock.sv
`default_nettype none
// ============================================================================
// Module   : sentinel_sequence_lock
// Purpose  : Multi-word key lock. Words are entered one per strobe rising
//            edge; the sequence is judged only after the last word so the
//            failing position is never revealed. Consecutive failures lead
//            to a timed lockout; an unlocked gate may relock on a timeout.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            bus       - sentinel_sequence_lock_if.slave (ena, key_in,
//                        key_strobe in; seg_out, status, unlocked, lockout,
//                        fail_count out)
// Revision : 1.0 - initial release
// ============================================================================
module sentinel_sequence_lock
    import sentinel_pkg::*;
#(
    parameter int                        KEY_W          = 8,
    parameter int                        KEY_LEN        = 4,
    parameter logic [KEY_W*KEY_LEN-1:0]  KEY            = 32'hB65AC31E,
    parameter int                        MAX_FAILS      = 3,
    parameter int                        LOCKOUT_CYCLES = 1024,
    parameter int                        UNLOCK_CYCLES  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    sentinel_sequence_lock_if.slave  bus
);
    localparam int IDX_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FC_W    = $clog2(MAX_FAILS + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_FAILS - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);

    generate
        if (KEY_LEN < 1) begin : g_bad_key_len
            $error("sentinel_sequence_lock: KEY_LEN must be >= 1");
        end
        if (MAX_FAILS < 1) begin : g_bad_max_fails
            $error("sentinel_sequence_lock: MAX_FAILS must be >= 1");
        end
        if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
            $error("sentinel_sequence_lock: LOCKOUT_CYCLES must be >= 1");
        end
    endgenerate

    sentinel_state_e   state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic              strobe_q;

    logic              rise;
    logic [KEY_W-1:0]  key_word;
    logic              err_all;
    logic              tmr_en;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_done;
    logic              tmr_blink;

    // strobe_q tracks the pin even while disabled, so a strobe that rose
    // with ena low is already "seen" when ena returns.
    assign rise     = bus.key_strobe & ~strobe_q & bus.ena;
    assign key_word = KEY[(KEY_LEN - 1 - int'(idx_q)) * KEY_W +: KEY_W];
    assign tmr_en   = bus.ena && (state_q != ST_LOCKED);

    sentinel_countdown #(
        .W   (TMR_W),
        .TAP (3)
    ) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .en       (tmr_en),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done),
        .tap      (tmr_blink)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_d        = err_q;
        fail_d       = fail_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        // mismatch flag including the word presented this cycle
        err_all      = err_q | (bus.key_in != key_word);

        case (state_q)
            ST_LOCKED: begin
                if (rise) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                        err_d = err_all;
                    end else begin
                        idx_d = '0;
                        err_d = 1'b0;
                        if (!err_all) begin
                            state_d      = ST_UNLOCKED;
                            fail_d       = '0;
                            tmr_load     = 1'b1;
                            tmr_load_val = TMR_W'(UNLOCK_CYCLES);
                        end else if (fail_q == FC_LAST) begin
                            state_d      = ST_LOCKOUT;
                            fail_d       = FC_MAX;
                            tmr_load     = 1'b1;
                            tmr_load_val = TMR_W'(LOCKOUT_CYCLES);
                        end else begin
                            fail_d = fail_q + FC_W'(1);
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                // timer stays at 0 (never done) when auto-relock is disabled
                if (rise || tmr_done) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOCKED;
            idx_q    <= '0;
            err_q    <= 1'b0;
            fail_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= bus.key_strobe;
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        bus.seg_out  = SEG_OFF;
        bus.status   = 8'h00;
        bus.unlocked = 1'b0;
        bus.lockout  = 1'b0;
        if (bus.ena) begin
            case (state_q)
                ST_LOCKED: begin
                    bus.seg_out = SEG_LOCKED;
                    bus.status  = therm8(32'(idx_q));
                end
                ST_UNLOCKED: begin
                    bus.seg_out  = SEG_UNLOCKED;
                    bus.status   = 8'hFF;
                    bus.unlocked = 1'b1;
                end
                ST_LOCKOUT: begin
                    bus.seg_out = SEG_LOCKOUT;
                    bus.status  = {8{tmr_blink}};
                    bus.lockout = 1'b1;
                end
                default: begin
                    bus.seg_out = SEG_OFF;
                end
            endcase
        end
    end

    assign bus.fail_count = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_sentinel_sequence_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_sentinel_sequence_lock
// Purpose  : Directed self-checking bench for sentinel_sequence_lock.
//            dut0 uses default parameters, dut1 has UNLOCK_CYCLES=16; each is
//            enabled only during its own phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sentinel_sequence_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena0 = 1'b1;
    logic       ena1 = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       key_strobe = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sentinel_sequence_lock_if #(.KEY_W(8), .MAX_FAILS(3)) if0 ();
    sentinel_sequence_lock_if #(.KEY_W(8), .MAX_FAILS(3)) if1 ();

    assign if0.ena        = ena0;
    assign if0.key_in     = key_in;
    assign if0.key_strobe = key_strobe;
    assign if1.ena        = ena1;
    assign if1.key_in     = key_in;
    assign if1.key_strobe = key_strobe;

    sentinel_sequence_lock dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    sentinel_sequence_lock #(.UNLOCK_CYCLES(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // expected {seg_out, status, unlocked, lockout, fail_count}
    typedef struct {
        int          dut;
        string       tag;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input string tag, input logic [7:0] seg,
                        input logic [7:0] st, input logic unl, input logic lo,
                        input logic [1:0] fc);
        exp_t e;
        e.dut = d;
        e.tag = tag;
        e.v   = {seg, st, unl, lo, fc};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [19:0] obs;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            if (e.dut == 0)
                obs = {if0.seg_out, if0.status, if0.unlocked, if0.lockout, if0.fail_count};
            else
                obs = {if1.seg_out, if1.status, if1.unlocked, if1.lockout, if1.fail_count};
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h {seg,status,unl,lo,fc}", e.tag, obs, e.v);
            end
        end
    endtask

    // check outputs as they stand now
    task automatic look(input int d, input string tag, input logic [7:0] seg,
                        input logic [7:0] st, input logic unl, input logic lo,
                        input logic [1:0] fc);
        push(d, tag, seg, st, unl, lo, fc);
        check();
    endtask

    // one strobe: outputs checked right after the rising-edge cycle
    task automatic enter(input int d, input logic [7:0] w, input string tag,
                         input logic [7:0] seg, input logic [7:0] st,
                         input logic unl, input logic lo, input logic [1:0] fc);
        key_in     = w;
        key_strobe = 1'b1;
        push(d, tag, seg, st, unl, lo, fc);
        step();
        check();
        key_strobe = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset
        step();
        step();
        rst = 1'b0;
        step();
        look(0, "reset_dut0", 8'hC7, 8'h00, 0, 0, 2'd0);
        look(1, "reset_dut1_off", 8'hFF, 8'h00, 0, 0, 2'd0);

        // correct sequence
        enter(0, 8'hB6, "good_w1", 8'hC7, 8'h01, 0, 0, 2'd0);
        enter(0, 8'h5A, "good_w2", 8'hC7, 8'h03, 0, 0, 2'd0);
        enter(0, 8'hC3, "good_w3", 8'hC7, 8'h07, 0, 0, 2'd0);
        enter(0, 8'h1E, "good_unlock", 8'hC1, 8'hFF, 1, 0, 2'd0);
        repeat (40) step();
        look(0, "no_autorelock", 8'hC1, 8'hFF, 1, 0, 2'd0);
        enter(0, 8'h00, "relock_any_key", 8'hC7, 8'h00, 0, 0, 2'd0);

        // wrong second word
        enter(0, 8'hB6, "bad2_w1", 8'hC7, 8'h01, 0, 0, 2'd0);
        enter(0, 8'h00, "bad2_w2", 8'hC7, 8'h03, 0, 0, 2'd0);
        enter(0, 8'hC3, "bad2_w3", 8'hC7, 8'h07, 0, 0, 2'd0);
        enter(0, 8'h1E, "bad2_eval", 8'hC7, 8'h00, 0, 0, 2'd1);

        // two more failures -> lockout
        for (int i = 0; i < 3; i++) enter(0, 8'h00, "fail2_w", 8'hC7, 8'(2 ** (i + 1) - 1), 0, 0, 2'd1);
        enter(0, 8'h00, "fail2_eval", 8'hC7, 8'h00, 0, 0, 2'd2);
        for (int i = 0; i < 3; i++) enter(0, 8'h00, "fail3_w", 8'hC7, 8'(2 ** (i + 1) - 1), 0, 0, 2'd2);
        // timer=1024 at entry: bit3 clear
        enter(0, 8'h00, "lockout_enter", 8'hBF, 8'h00, 0, 1, 2'd3);
        // timer 1022 and 1020: bit3 set
        enter(0, 8'hB6, "lockout_ignore1", 8'hBF, 8'hFF, 0, 1, 2'd3);
        enter(0, 8'hB6, "lockout_ignore2", 8'hBF, 8'hFF, 0, 1, 2'd3);
        repeat (1018) step();
        look(0, "lockout_last_cycle", 8'hBF, 8'h00, 0, 1, 2'd3);
        step();
        look(0, "lockout_expired", 8'hC7, 8'h00, 0, 0, 2'd0);

        // held strobe yields one entry
        key_in     = 8'hB6;
        key_strobe = 1'b1;
        repeat (10) step();
        look(0, "held_strobe", 8'hC7, 8'h01, 0, 0, 2'd0);
        key_strobe = 1'b0;
        step();
        enter(0, 8'h5A, "resume_w2", 8'hC7, 8'h03, 0, 0, 2'd0);

        // ena low mid-entry, with a strobe rising while disabled
        ena0 = 1'b0;
        step();
        look(0, "ena_low", 8'hFF, 8'h00, 0, 0, 2'd0);
        key_in     = 8'hC3;
        key_strobe = 1'b1;
        step();
        ena0 = 1'b1;
        step();
        look(0, "ena_back_no_entry", 8'hC7, 8'h03, 0, 0, 2'd0);
        key_strobe = 1'b0;
        step();
        enter(0, 8'hC3, "ena_w3", 8'hC7, 8'h07, 0, 0, 2'd0);
        enter(0, 8'h1E, "ena_unlock", 8'hC1, 8'hFF, 1, 0, 2'd0);
        enter(0, 8'h00, "ena_relock", 8'hC7, 8'h00, 0, 0, 2'd0);

        // reset mid-entry with a nonzero fail count
        for (int i = 0; i < 3; i++) enter(0, 8'h11, "pre_rst_w", 8'hC7, 8'(2 ** (i + 1) - 1), 0, 0, 2'd0);
        enter(0, 8'h11, "pre_rst_eval", 8'hC7, 8'h00, 0, 0, 2'd1);
        enter(0, 8'hB6, "pre_rst_g1", 8'hC7, 8'h01, 0, 0, 2'd1);
        enter(0, 8'h5A, "pre_rst_g2", 8'hC7, 8'h03, 0, 0, 2'd1);
        rst = 1'b1;
        step();
        look(0, "mid_entry_reset", 8'hC7, 8'h00, 0, 0, 2'd0);
        rst = 1'b0;
        enter(0, 8'hB6, "post_rst_w1", 8'hC7, 8'h01, 0, 0, 2'd0);
        enter(0, 8'h5A, "post_rst_w2", 8'hC7, 8'h03, 0, 0, 2'd0);
        enter(0, 8'hC3, "post_rst_w3", 8'hC7, 8'h07, 0, 0, 2'd0);
        enter(0, 8'h1E, "post_rst_unlock", 8'hC1, 8'hFF, 1, 0, 2'd0);

        // auto-relock on dut1
        ena0 = 1'b0;
        ena1 = 1'b1;
        step();
        look(1, "dut1_locked", 8'hC7, 8'h00, 0, 0, 2'd0);
        enter(1, 8'hB6, "d1_w1", 8'hC7, 8'h01, 0, 0, 2'd0);
        enter(1, 8'h5A, "d1_w2", 8'hC7, 8'h03, 0, 0, 2'd0);
        enter(1, 8'hC3, "d1_w3", 8'hC7, 8'h07, 0, 0, 2'd0);
        enter(1, 8'h1E, "d1_unlock", 8'hC1, 8'hFF, 1, 0, 2'd0);
        repeat (14) step();
        look(1, "d1_unlock_cycle15", 8'hC1, 8'hFF, 1, 0, 2'd0);
        // strobe rises exactly on the expiry cycle
        enter(1, 8'hB6, "d1_relock_expiry", 8'hC7, 8'h00, 0, 0, 2'd0);
        look(1, "d1_rise_not_counted", 8'hC7, 8'h00, 0, 0, 2'd0);
        enter(1, 8'hB6, "d1_entry_after", 8'hC7, 8'h01, 0, 0, 2'd0);
        look(0, "dut0_frozen_unlocked", 8'hFF, 8'h00, 0, 0, 2'd0);

        n_cmp++;
        assert (sb.size() === 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
